// File: rtl/tdm_demux_sequencer.sv
// TDM frame sequencer: takes 8-bit words over valid/ready and serialises them onto a 1:8 demux.
// Latency: handshake at edge k -> slot 0 on I/S from edge k; each slot lasts DWELL cycles.
// Backpressure: DIN_READY is high in IDLE and on slot 7's final dwell cycle only.
// Build option: define TDM_SEQ_MSB_FIRST_EN to send DIN[7-n] in slot n (default is LSB first).
module tdm_demux_sequencer #(
  parameter int unsigned DWELL = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  output logic       I,
  output logic [2:0] S,
  output logic       SLOT_EN,
  output logic       FRAME_DONE,
  output logic       BUSY
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Final value of the dwell counter within a slot; DWELL is limited to 1..16.
  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_t     state_q, state_d;
  logic [7:0] word_q, word_d;
  logic [2:0] slot_q, slot_d;
  logic [3:0] dwell_q, dwell_d;
  logic       i_q, i_d;
  logic       en_q, en_d;
  logic       done_q, done_d;

  logic       last_dwell;
  logic       frame_end;
  logic       ready;
  logic       take;

  // Picks the word bit carried in a given slot; the bit order is a build option.
  function automatic logic bit_sel(input logic [7:0] w, input logic [2:0] slot);
    logic [2:0] idx;
`ifdef TDM_SEQ_MSB_FIRST_EN
    idx = ~slot;          // 7 - slot for a 3-bit slot number
`else
    idx = slot;
`endif
    return w[idx];
  endfunction

  assign last_dwell = (dwell_q == DWELL_LAST);
  assign frame_end  = (state_q == ST_SHIFT) && (slot_q == 3'd7) && last_dwell;

  // Ready is combinational so a new word can be taken on the very edge that ends slot 7,
  // giving back-to-back frames without an idle bubble. Held low while reset is asserted.
  assign ready = !RST && ((state_q == ST_IDLE) || frame_end);
  assign take  = DIN_VALID && ready;

  // Next-state and next-output logic; all visible outputs except ready come from registers.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    slot_d  = slot_q;
    dwell_d = dwell_q;
    i_d     = i_q;
    en_d    = en_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        slot_d  = 3'd0;
        dwell_d = 4'd0;
        i_d     = 1'b0;
        en_d    = 1'b0;
        if (take) begin
          word_d  = DIN;
          i_d     = bit_sel(DIN, 3'd0);
          en_d    = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (last_dwell) begin
          dwell_d = 4'd0;
          if (slot_q == 3'd7) begin
            // Frame complete: pulse done in the following cycle whether or not
            // a new word follows straight away.
            done_d = 1'b1;
            if (take) begin
              word_d  = DIN;
              slot_d  = 3'd0;
              i_d     = bit_sel(DIN, 3'd0);
              en_d    = 1'b1;
            end else begin
              slot_d  = 3'd0;
              i_d     = 1'b0;
              en_d    = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            slot_d = slot_q + 3'd1;
            i_d    = bit_sel(word_q, slot_q + 3'd1);
          end
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        slot_d  = 3'd0;
        dwell_d = 4'd0;
        i_d     = 1'b0;
        en_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame without a done pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      word_q  <= 8'd0;
      slot_q  <= 3'd0;
      dwell_q <= 4'd0;
      i_q     <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      slot_q  <= slot_d;
      dwell_q <= dwell_d;
      i_q     <= i_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign DIN_READY  = ready;
  assign I          = i_q;
  assign S          = slot_q;
  assign SLOT_EN    = en_q;
  assign BUSY       = en_q;
  assign FRAME_DONE = done_q;

endmodule
